mfp_ahb_lite_master: RTL and testbench

//  AHB-Lite initiator for the MIPSfpga+ system bus: turns a valid/ready command stream into SINGLE

---
 rtl/mfp_ahb_lite_master.sv | 128 ++++++++++++
 tb/tb_mfp_ahb_lite_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_lite_master.sv
// AHB-Lite initiator: turns a valid/ready command stream into SINGLE NONSEQ transfers with
// overlapped address/data phases, and reports one response per completed transfer.
module mfp_ahb_lite_master #(
   parameter logic [3:0]  HPROT_VAL  = 4'b0011,
   parameter int unsigned WCNT_WIDTH = 16
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [31:0]           cmd_addr,
   input  logic                  cmd_write,
   input  logic [2:0]            cmd_size,
   input  logic [31:0]           cmd_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_write,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic [WCNT_WIDTH-1:0] stat_wait_cnt,
   output logic [31:0]           HADDR,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [1:0]            HTRANS,
   output logic [31:0]           HWDATA,
   output logic [2:0]            HBURST,
   output logic                  HMASTLOCK,
   output logic [3:0]            HPROT,
   input  logic [31:0]           HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP
);

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_NONSEQ = 2'b10
   } htrans_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [31:0] wdata;
   } a_slot_t;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic [31:0] wdata;
   } d_slot_t;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic        err;
      logic [31:0] rdata;
   } rsp_t;

   localparam a_slot_t A_RESET = '{valid: 1'b0, addr: 32'h0, write: 1'b0, size: 3'b010, wdata: 32'h0};
   localparam logic [WCNT_WIDTH-1:0] WCNT_ONE = 1;

   a_slot_t               a_q, a_d;
   d_slot_t               d_q, d_d;
   rsp_t                  rsp_q, rsp_d;
   logic [WCNT_WIDTH-1:0] wcnt_q, wcnt_d;

   // The whole pipeline moves only on HREADY, so the master is ready exactly when the bus is.
   assign cmd_ready = HREADY;

   // NOTE: every variable gets its default before any branch so no path can infer a latch.
   always_comb begin
      a_d       = a_q;
      d_d       = d_q;
      rsp_d     = rsp_q;
      rsp_d.valid = 1'b0;
      wcnt_d    = wcnt_q;
      if (HREADY) begin
         d_d.valid = a_q.valid;
         d_d.write = a_q.write;
         d_d.wdata = (a_q.valid && a_q.write) ? a_q.wdata : 32'h0;
         a_d.valid = cmd_valid;
         if (cmd_valid) begin
            a_d.addr  = cmd_addr;
            a_d.write = cmd_write;
            a_d.size  = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
            a_d.wdata = cmd_wdata;
         end
         if (d_q.valid) begin
            rsp_d.valid = 1'b1;
            rsp_d.write = d_q.write;
            rsp_d.err   = HRESP;
            rsp_d.rdata = (!d_q.write && !HRESP) ? HRDATA : 32'h0;
         end
      end else if (d_q.valid && (wcnt_q != '1)) begin
         wcnt_d = wcnt_q + WCNT_ONE;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_q    <= A_RESET;
         d_q    <= '0;
         rsp_q  <= '0;
         wcnt_q <= '0;
      end else begin
         a_q    <= a_d;
         d_q    <= d_d;
         rsp_q  <= rsp_d;
         wcnt_q <= wcnt_d;
      end
   end

   assign HTRANS        = a_q.valid ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR         = a_q.addr;
   assign HWRITE        = a_q.write;
   assign HSIZE         = a_q.size;
   assign HWDATA        = d_q.wdata;
   assign HBURST        = 3'b000;
   assign HMASTLOCK     = 1'b0;
   assign HPROT         = HPROT_VAL;
   assign rsp_valid     = rsp_q.valid;
   assign rsp_write     = rsp_q.write;
   assign rsp_err       = rsp_q.err;
   assign rsp_rdata     = rsp_q.rdata;
   assign stat_wait_cnt = wcnt_q;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Bench for mfp_ahb_lite_master: a behavioural AHB slave with wait/error injection plus an
// in-order transaction model that predicts every address phase and response.
module tb_mfp_ahb_lite_master;

   localparam int WCW = 4;

   logic            HCLK = 1'b0;
   logic            HRESETn = 1'b0;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [31:0]     cmd_addr = '0;
   logic            cmd_write = 1'b0;
   logic [2:0]      cmd_size = '0;
   logic [31:0]     cmd_wdata = '0;
   logic            rsp_valid, rsp_write, rsp_err;
   logic [31:0]     rsp_rdata;
   logic [WCW-1:0]  stat_wait_cnt;
   logic [31:0]     HADDR, HWDATA;
   logic            HWRITE, HMASTLOCK;
   logic [2:0]      HSIZE, HBURST;
   logic [1:0]      HTRANS;
   logic [3:0]      HPROT;
   logic [31:0]     hrdata = '0;
   logic            hready = 1'b1;
   logic            hresp = 1'b0;

   always #5 HCLK = ~HCLK;

   mfp_ahb_lite_master #(.HPROT_VAL(4'b0011), .WCNT_WIDTH(WCW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_write(cmd_write),
      .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .stat_wait_cnt(stat_wait_cnt),
      .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA),
      .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
      .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp)
   );

   typedef struct {
      logic [31:0] addr;
      logic        w;
      logic [2:0]  size;
      logic [31:0] wdata;
   } cmd_t;

   typedef struct {
      logic        w;
      logic        err;
      logic [31:0] rdata;
      int          acc;
      int          lat;
   } rsp_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        w;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [2:0]  exp_hsize;
      logic [31:0] exp_rdata;
   } vec_t;

   cmd_t        cmd_q[$];
   cmd_t        aph_q[$];
   rsp_exp_t    rsp_q[$];
   logic [31:0] ref_mem[64];
   logic [31:0] sl_mem[64];

   int n_checks = 0;
   int n_fail   = 0;

   // Slave data-phase state and configuration
   bit          sl_dp_valid = 0, sl_dp_w = 0, sl_dp_err = 0, sl_err_stage = 0;
   logic [31:0] sl_dp_addr = '0;
   int          sl_dp_wait = 0;
   int          cfg_wait = 0, slow_wait = 0;
   bit          rand_waits = 0, slow_en = 0, err_en = 0, chk_lat = 0, rand_gaps = 0;
   logic [31:0] slow_addr = '0, err_addr = '0;

   int          cyc = 0, exp_wait = 0, rsp_cnt = 0, ready_low = 0;
   logic [2:0]  last_hsize = '0;
   logic [31:0] last_rdata = '0;
   logic        last_err = 1'b0;
   bit          prev_hready = 1;
   logic [31:0] prev_haddr = '0;
   logic [5:0]  prev_ctrl = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int idx(input logic [31:0] a);
      return int'(a[7:2]);
   endfunction

   function automatic bit is_err(input logic [31:0] a);
      return err_en && (a == err_addr);
   endfunction

   // Transaction-level model: commands complete in order against a word memory.
   task automatic model_accept(input cmd_t c);
      rsp_exp_t e;
      e.w   = c.w;
      e.err = is_err(c.addr);
      e.acc = cyc;
      e.lat = chk_lat ? 3 + cfg_wait : -1;
      e.rdata = 32'h0;
      if (c.w) begin
         if (!e.err) ref_mem[idx(c.addr)] = c.wdata;
      end else if (!e.err) begin
         e.rdata = ref_mem[idx(c.addr)];
      end
      rsp_q.push_back(e);
      aph_q.push_back(c);
   endtask

   task automatic tick();
      rsp_exp_t e;
      cmd_t     c;
      @(negedge HCLK);
      cyc++;
      if (rsp_valid) begin
         rsp_cnt++;
         last_rdata = rsp_rdata;
         last_err   = rsp_err;
         check("rsp_expected", 32'(rsp_q.size() != 0), 32'h1);
         if (rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            check("rsp_write", 32'(rsp_write), 32'(e.w));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("rsp_rdata", rsp_rdata, e.rdata);
            if (e.lat >= 0) check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
      if (!prev_hready) begin
         check("hold_haddr", HADDR, prev_haddr);
         check("hold_ctrl", 32'({HTRANS, HWRITE, HSIZE}), 32'(prev_ctrl));
      end
      prev_haddr = HADDR;
      prev_ctrl  = {HTRANS, HWRITE, HSIZE};

      // Slave: finish or stretch the current data phase, then sample the address phase.
      hrdata = $urandom;
      hresp  = 1'b0;
      if (!sl_dp_valid) begin
         hready = 1'b1;
      end else if (sl_dp_err) begin
         hresp        = 1'b1;
         hready       = sl_err_stage;
         sl_err_stage = 1;
      end else if (sl_dp_wait > 0) begin
         hready = 1'b0;
         sl_dp_wait--;
      end else begin
         hready = 1'b1;
         if (sl_dp_w) sl_mem[idx(sl_dp_addr)] = HWDATA;
         else hrdata = sl_mem[idx(sl_dp_addr)];
      end
      if (!hready) exp_wait++;
      if (hready) begin
         sl_dp_valid = (HTRANS == 2'b10);
         if (sl_dp_valid) begin
            sl_dp_addr   = HADDR;
            sl_dp_w      = HWRITE;
            sl_dp_err    = is_err(HADDR);
            sl_err_stage = 0;
            if (sl_dp_err) sl_dp_wait = 0;
            else if (rand_waits) sl_dp_wait = int'($urandom_range(0, 2));
            else if (slow_en && HADDR == slow_addr) sl_dp_wait = slow_wait;
            else sl_dp_wait = cfg_wait;
            last_hsize = HSIZE;
            check("transfer_expected", 32'(aph_q.size() != 0), 32'h1);
            if (aph_q.size() != 0) begin
               c = aph_q.pop_front();
               check("haddr", HADDR, c.addr);
               check("hwrite", 32'(HWRITE), 32'(c.w));
               check("hsize", 32'(HSIZE), (c.size > 3'd2) ? 32'h2 : 32'(c.size));
            end
            check("hconst", 32'({HBURST, HMASTLOCK, HPROT}), 32'h03);
         end
      end

      if (cmd_q.size() != 0 && !(rand_gaps && $urandom_range(0, 3) == 0)) begin
         c = cmd_q[0];
         cmd_valid = 1'b1;
         cmd_addr  = c.addr;
         cmd_write = c.w;
         cmd_size  = c.size;
         cmd_wdata = c.wdata;
         if (hready) begin
            void'(cmd_q.pop_front());
            model_accept(c);
         end
      end else begin
         cmd_valid = 1'b0;
         cmd_addr  = $urandom;
         cmd_wdata = $urandom;
      end
      prev_hready = hready;
      #1;
      check("cmd_ready", 32'(cmd_ready), 32'(hready));
      if (!cmd_ready) ready_low++;
   endtask

   task automatic push(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
      cmd_t c;
      c.addr = a; c.w = w; c.size = s; c.wdata = d;
      cmd_q.push_back(c);
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((cmd_q.size() != 0 || rsp_q.size() != 0) && n < max) begin
         tick();
         n++;
      end
      check("drain_done", 32'(cmd_q.size() + rsp_q.size()), 32'h0);
      tick();
   endtask

   task automatic do_reset();
      @(negedge HCLK);
      HRESETn   = 1'b0;
      cmd_valid = 1'b0;
      hready    = 1'b1;
      hresp     = 1'b0;
      sl_dp_valid = 0; sl_err_stage = 0;
      cmd_q.delete(); aph_q.delete(); rsp_q.delete();
      exp_wait = 0; rsp_cnt = 0; ready_low = 0; prev_hready = 1;
      cfg_wait = 0; rand_waits = 0; slow_en = 0; err_en = 0; chk_lat = 0; rand_gaps = 0;
      #1;
      check("reset_htrans", 32'(HTRANS), 32'h0);
      check("reset_haddr", HADDR, 32'h0);
      check("reset_hwrite_hsize", 32'({HWRITE, HSIZE}), 32'h2);
      check("reset_hwdata", HWDATA, 32'h0);
      check("reset_rsp", 32'({rsp_valid, rsp_write, rsp_err}), 32'h0);
      check("reset_rsp_rdata", rsp_rdata, 32'h0);
      check("reset_stat", 32'(stat_wait_cnt), 32'h0);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[6];
      logic [31:0] saved;
      tbl[0] = '{32'h20, 1'b1, 3'd0, 32'h000000AB, 3'd0, 32'h0};
      tbl[1] = '{32'h24, 1'b1, 3'd1, 32'h0000BEEF, 3'd1, 32'h0};
      tbl[2] = '{32'h28, 1'b1, 3'd3, 32'h12345678, 3'd2, 32'h0};
      tbl[3] = '{32'h20, 1'b0, 3'd2, 32'h0,        3'd2, 32'h000000AB};
      tbl[4] = '{32'h24, 1'b0, 3'd7, 32'h0,        3'd2, 32'h0000BEEF};
      tbl[5] = '{32'h28, 1'b0, 3'd1, 32'h0,        3'd1, 32'h12345678};
      for (int i = 0; i < 64; i++) begin
         ref_mem[i] = $urandom;
         sl_mem[i]  = ref_mem[i];
      end

      // Zero-wait write then read-back, with latency checked
      do_reset();
      chk_lat = 1;
      push(32'h10, 1'b1, 3'd2, 32'hCAFEBABE);
      push(32'h10, 1'b0, 3'd2, 32'h0);
      drain(20);
      check("t1_rsp_cnt", 32'(rsp_cnt), 32'h2);
      check("t1_rdata", last_rdata, 32'hCAFEBABE);
      check("t1_err", 32'(last_err), 32'h0);
      check("t1_stat", 32'(stat_wait_cnt), 32'h0);

      // Size mapping and read-back from a vector table
      do_reset();
      chk_lat = 1;
      for (int i = 0; i < 6; i++) begin
         push(tbl[i].addr, tbl[i].w, tbl[i].size, tbl[i].wdata);
         drain(20);
         check("tbl_hsize", 32'(last_hsize), 32'(tbl[i].exp_hsize));
         check("tbl_rdata", last_rdata, tbl[i].exp_rdata);
      end

      // One-wait slave, 4 back-to-back writes then 4 reads
      do_reset();
      cfg_wait = 1;
      for (int i = 0; i < 4; i++) push(32'(i * 4), 1'b1, 3'd2, 32'h10000000 + 32'(i) * 32'h111);
      for (int i = 0; i < 4; i++) push(32'(i * 4), 1'b0, 3'd2, 32'h0);
      drain(60);
      check("t2_rsp_cnt", 32'(rsp_cnt), 32'h8);
      check("t2_last_rdata", last_rdata, 32'h10000333);
      check("t2_stat", 32'(stat_wait_cnt), 32'h8);

      // Long stall on one read with following commands queued behind it
      do_reset();
      slow_en = 1; slow_addr = 32'h10; slow_wait = 5;
      push(32'h10, 1'b0, 3'd2, 32'h0);
      push(32'h14, 1'b0, 3'd2, 32'h0);
      push(32'h18, 1'b0, 3'd2, 32'h0);
      drain(40);
      check("t3_ready_low", 32'(ready_low), 32'h5);
      check("t3_stat", 32'(stat_wait_cnt), 32'h5);
      check("t3_rsp_cnt", 32'(rsp_cnt), 32'h3);

      // ERROR on a write with a read pipelined behind it
      do_reset();
      push(32'h44, 1'b1, 3'd2, 32'h5555AAAA);
      drain(20);
      err_en = 1; err_addr = 32'h40;
      push(32'h40, 1'b1, 3'd2, 32'hDEADBEEF);
      push(32'h44, 1'b0, 3'd2, 32'h0);
      drain(20);
      check("t4_err_cleared", 32'(last_err), 32'h0);
      check("t4_rdata", last_rdata, 32'h5555AAAA);
      check("t4_stat", 32'(stat_wait_cnt), 32'h1);
      push(32'h40, 1'b0, 3'd2, 32'h0);
      drain(20);
      check("t4_rsp_cnt", 32'(rsp_cnt), 32'h4);

      // Reset with a read in data phase and a write in address phase
      do_reset();
      saved = ref_mem[idx(32'h14)];
      push(32'h10, 1'b0, 3'd2, 32'h0);
      push(32'h14, 1'b1, 3'd2, 32'h00000077);
      tick();
      tick();
      @(negedge HCLK);
      check("t5_inflight", 32'({HTRANS, HWRITE, HADDR[7:0]}), 32'({2'b10, 1'b1, 8'h14}));
      cmd_valid = 1'b0;
      HRESETn   = 1'b0;
      #1;
      check("t5_rst_htrans", 32'(HTRANS), 32'h0);
      check("t5_rst_rsp", 32'(rsp_valid), 32'h0);
      do_reset();
      ref_mem[idx(32'h14)] = saved;
      repeat (4) tick();
      check("t5_no_rsp", 32'(rsp_cnt), 32'h0);
      chk_lat = 1;
      push(32'h14, 1'b0, 3'd2, 32'h0);
      drain(20);
      check("t5_after_rdata", last_rdata, saved);

      // Randomized traffic with random waits, gaps and errors against the model
      do_reset();
      rand_waits = 1; rand_gaps = 1; err_en = 1; err_addr = 32'h3C;
      for (int i = 0; i < 200; i++)
         push(32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), $urandom);
      drain(3000);
      check("rand_rsp_cnt", 32'(rsp_cnt), 32'd200);
      check("rand_stat", 32'(stat_wait_cnt), (exp_wait > 15) ? 32'd15 : 32'(exp_wait));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
